// File: rtl/imem_boot_writer_if.sv
// Bus bundle for imem_boot_writer: loader stream, CPU fetch port and load status.
interface imem_boot_writer_if #(
  parameter int ADDR_W = 6
);
  logic [31:0]     in_data;
  logic [31:0]     in_address;
  logic [31:0]     cpu_pc;
  logic [31:0]     cpu_instr;
  logic            cpu_reset;
  logic            load_done;
  logic [ADDR_W:0] load_count;
  logic            addr_error;
  logic            verify_mismatch;

  modport master (
    output in_data, in_address, cpu_pc,
    input  cpu_instr, cpu_reset, load_done, load_count, addr_error, verify_mismatch
  );

  modport slave (
    input  in_data, in_address, cpu_pc,
    output cpu_instr, cpu_reset, load_done, load_count, addr_error, verify_mismatch
  );
endinterface

// File: rtl/imem_boot_writer.sv
// Boot-time instruction memory loader: captures an ordered word stream, then releases the CPU.
// Define IMEM_BOOT_VERIFY_EN to add a readback-compare pass before the CPU is released.
module imem_boot_writer #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic               clock,
  input  logic               reset,
  imem_boot_writer_if.slave  bus
);
  localparam int DATA_W = 32;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {SYNC, LOAD, VERIFY, DONE} state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   prev, prev_n, prev_inc;
  logic [ADDR_W:0]     load_count, count_n;
  logic                addr_error, err_n;
  logic                load_done, cpu_reset;
  logic                we;
  logic [DATA_W-1:0]   instr_p1;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic [ADDR_W-1:0]   idx;
  logic                in_range, addr_zero, seq_ok;
  logic [ADDR_W-1:0]   pc_idx;
  logic                pc_in_range;
  logic                unused_pc;

  assign idx       = bus.in_address[ADDR_W-1:0];
  assign in_range  = (bus.in_address[31:ADDR_W] == '0);
  assign addr_zero = (bus.in_address == 32'd0);
  assign prev_inc  = prev + ADDR_W'(1);
  // A wrap from LAST back to 0 never reaches this test: writing LAST always leaves LOAD.
  assign seq_ok    = in_range && (idx == prev_inc);

  assign pc_idx      = bus.cpu_pc[ADDR_W+1:2];
  assign pc_in_range = (bus.cpu_pc[31:ADDR_W+2] == '0);
  assign unused_pc   = ^bus.cpu_pc[1:0];

`ifdef IMEM_BOOT_VERIFY_EN
  logic vact, vact_n;
  logic verify_mismatch, mis_n;
`endif

  always_comb begin
    state_n = state;
    prev_n  = prev;
    count_n = load_count;
    err_n   = addr_error;
    we      = 1'b0;
`ifdef IMEM_BOOT_VERIFY_EN
    vact_n  = vact;
    mis_n   = verify_mismatch;
`endif
    case (state)
      SYNC: begin
        if (addr_zero) begin
          we      = 1'b1;
          prev_n  = '0;
          count_n = (ADDR_W+1)'(1);
          state_n = LOAD;
        end
      end
      LOAD: begin
        if (seq_ok) begin
          we      = 1'b1;
          prev_n  = idx;
          count_n = load_count + (ADDR_W+1)'(1);
          if (idx == LAST) begin
`ifdef IMEM_BOOT_VERIFY_EN
            state_n = VERIFY;
            vact_n  = 1'b0;
`else
            state_n = DONE;
`endif
          end
        end else begin
          err_n   = 1'b1;
          count_n = '0;
          state_n = SYNC;
        end
      end
`ifdef IMEM_BOOT_VERIFY_EN
      VERIFY: begin
        // Compare pass arms on address 0; an ordering fault disarms until the next 0.
        if (!vact) begin
          if (addr_zero) begin
            vact_n = 1'b1;
            prev_n = '0;
            if (bus.in_data != mem[idx]) mis_n = 1'b1;
          end
        end else if (seq_ok) begin
          prev_n = idx;
          if (bus.in_data != mem[idx]) mis_n = 1'b1;
          if (idx == LAST) state_n = DONE;
        end else begin
          err_n  = 1'b1;
          vact_n = 1'b0;
        end
      end
`endif
      DONE: begin
      end
      default: state_n = SYNC;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= SYNC;
      prev       <= '0;
      load_count <= '0;
      addr_error <= 1'b0;
      load_done  <= 1'b0;
      cpu_reset  <= 1'b1;
`ifdef IMEM_BOOT_VERIFY_EN
      vact            <= 1'b0;
      verify_mismatch <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      prev       <= prev_n;
      load_count <= count_n;
      addr_error <= err_n;
      load_done  <= (state_n == DONE);
      cpu_reset  <= (state_n != DONE);
`ifdef IMEM_BOOT_VERIFY_EN
      vact            <= vact_n;
      verify_mismatch <= mis_n;
`endif
    end
  end

  // Memory write: contents survive reset, but a reset cycle never writes.
  always_ff @(posedge clock) begin
    if (we && !reset) mem[idx] <= bus.in_data;
  end

  // Fetch stage p1: out-of-range or pre-release fetches return NOP.
  always_ff @(posedge clock) begin
    if (reset)                            instr_p1 <= '0;
    else if (state == DONE && pc_in_range) instr_p1 <= mem[pc_idx];
    else                                  instr_p1 <= '0;
  end

  assign bus.cpu_instr  = instr_p1;
  assign bus.cpu_reset  = cpu_reset;
  assign bus.load_done  = load_done;
  assign bus.load_count = load_count;
  assign bus.addr_error = addr_error;
`ifdef IMEM_BOOT_VERIFY_EN
  assign bus.verify_mismatch = verify_mismatch;
`else
  assign bus.verify_mismatch = 1'b0;
`endif
endmodule

// File: tb/tb_imem_boot_writer.sv
// Directed bench for imem_boot_writer; CPU fetches are checked through an expected-value queue.
module tb_imem_boot_writer;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_pass;
  logic [31:0] model [DEPTH];
  logic [31:0] sb_q [$];

  imem_boot_writer_if #(.ADDR_W(ADDR_W)) bus ();

  imem_boot_writer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] addr, input logic [31:0] data);
    bus.in_address = addr;
    bus.in_data    = data;
    tick();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cpu_reset"}, 64'(bus.cpu_reset), 64'd1);
    check({tag, "_load_done"}, 64'(bus.load_done), 64'd0);
    check({tag, "_load_count"}, 64'(bus.load_count), 64'd0);
    check({tag, "_addr_error"}, 64'(bus.addr_error), 64'd0);
    check({tag, "_verify_mismatch"}, 64'(bus.verify_mismatch), 64'd0);
    check({tag, "_cpu_instr"}, 64'(bus.cpu_instr), 64'd0);
  endtask

  // Expected fetch result is queued when the PC is driven, compared when the word comes back.
  task automatic fetch(input logic [31:0] pc, input logic in_done);
    logic [31:0] exp;
    logic [31:0] got;
    bus.cpu_pc = pc;
    exp = (in_done && pc[31:ADDR_W+2] == '0) ? model[pc[ADDR_W+1:2]] : 32'd0;
    sb_q.push_back(exp);
    tick();
    if (sb_q.size() == 0) begin
      check("fetch_queue_empty", 64'd0, 64'd1);
    end else begin
      got = sb_q.pop_front();
      check($sformatf("fetch_pc_%h", pc), 64'(bus.cpu_instr), 64'(got));
    end
  endtask

  // Full load of 0..DEPTH-1; verify builds follow with a second pass, optionally altering one word.
  task automatic full_pass(input logic [31:0] base, input int alter, input logic exp_err);
    for (int a = 0; a < DEPTH; a++) begin
      drive(32'(a), base + 32'(a));
      model[a] = base + 32'(a);
      if (a == 0) check("pass_count_first", 64'(bus.load_count), 64'd1);
      if (a == 30) check("pass_instr_pre_done", 64'(bus.cpu_instr), 64'd0);
      if (a == DEPTH - 2) begin
        check("pass_cpu_reset_held", 64'(bus.cpu_reset), 64'd1);
        check("pass_done_low", 64'(bus.load_done), 64'd0);
      end
    end
`ifdef IMEM_BOOT_VERIFY_EN
    check("verify_count_hold", 64'(bus.load_count), 64'(DEPTH));
    check("verify_not_done", 64'(bus.load_done), 64'd0);
    for (int a = 0; a < DEPTH; a++) begin
      drive(32'(a), base + 32'(a) + ((a == alter) ? 32'h0000_1000 : 32'd0));
      if (a == DEPTH - 2) check("verify_cpu_reset_held", 64'(bus.cpu_reset), 64'd1);
    end
    check("verify_mismatch_flag", 64'(bus.verify_mismatch), (alter >= 0) ? 64'd1 : 64'd0);
`else
    check("verify_mismatch_tied", 64'(bus.verify_mismatch), 64'd0);
`endif
    check("pass_load_done", 64'(bus.load_done), 64'd1);
    check("pass_cpu_reset_low", 64'(bus.cpu_reset), 64'd0);
    check("pass_load_count", 64'(bus.load_count), 64'(DEPTH));
    check("pass_addr_error", 64'(bus.addr_error), 64'(exp_err));
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset = 1'b1;
    bus.in_address = 32'hFFFF_FFFF;
    bus.in_data    = 32'd0;
    bus.cpu_pc     = 32'h0000_0008;
    for (int a = 0; a < DEPTH; a++) model[a] = 32'd0;
    tick();
    tick();
    check_reset_values("reset");
    reset = 1'b0;

    // Stream joined mid-way: ignored until address 0.
    drive(32'd17, 32'hAAAA_0017);
    drive(32'd18, 32'hAAAA_0018);
    drive(32'd19, 32'hAAAA_0019);
    check("sync_ignore_count", 64'(bus.load_count), 64'd0);
    check("sync_ignore_err", 64'(bus.addr_error), 64'd0);
    drive(32'h0000_0100, 32'hAAAA_0100);
    check("sync_oor_err", 64'(bus.addr_error), 64'd0);
    full_pass(32'h2000_0000, -1, 1'b0);

    // DONE ignores the stream; memory untouched.
    drive(32'd0, 32'hDEAD_BEEF);
    drive(32'd1, 32'hDEAD_BEEF);
    check("done_stays", 64'(bus.load_done), 64'd1);
    fetch(32'h0000_0008, 1'b1);
    fetch(32'h0000_0100, 1'b1);
    fetch(32'h0000_000B, 1'b1);
    fetch(32'h0000_00FC, 1'b1);
    fetch(32'h0000_0000, 1'b1);
    fetch(32'h8000_0004, 1'b1);

    // Ordering fault: 0,1,2,5.
    reset = 1'b1;
    tick();
    check_reset_values("reset2");
    reset = 1'b0;
    drive(32'd0, 32'h3000_0000);
    drive(32'd1, 32'h3000_0001);
    drive(32'd2, 32'h3000_0002);
    check("seq_count_3", 64'(bus.load_count), 64'd3);
    drive(32'd5, 32'h3000_0005);
    check("seq_err_flag", 64'(bus.addr_error), 64'd1);
    check("seq_err_count", 64'(bus.load_count), 64'd0);
    drive(32'd7, 32'h3000_0007);
    check("seq_sync_count", 64'(bus.load_count), 64'd0);
    check("seq_sync_cpu_reset", 64'(bus.cpu_reset), 64'd1);
    full_pass(32'h3000_0000, -1, 1'b1);
    fetch(32'h0000_0008, 1'b1);

    // Out-of-range address inside LOAD.
    reset = 1'b1;
    tick();
    check_reset_values("reset3");
    reset = 1'b0;
    drive(32'd0, 32'h3100_0000);
    drive(32'h0000_0041, 32'h3100_0001);
    check("oor_err_flag", 64'(bus.addr_error), 64'd1);
    check("oor_err_count", 64'(bus.load_count), 64'd0);

    // Reset in the middle of a pass.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int a = 0; a < 30; a++) drive(32'(a), 32'h4000_0000 + 32'(a));
    check("mid_count", 64'(bus.load_count), 64'd30);
    reset = 1'b1;
    drive(32'd30, 32'h4000_001E);
    check_reset_values("mid_reset");
    reset = 1'b0;
    full_pass(32'h5000_0000, 9, 1'b0);
    fetch(32'h0000_0078, 1'b1);
    fetch(32'h0000_0024, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/imem_boot_writer.md
IMEM_BOOT_WRITER -- requirements
Module: imem_boot_writer

Interface
REQ-001 SHALL have parameter DEPTH, default 64, instruction words stored (power of two, 4..1024).
REQ-002 SHALL have parameter ADDR_W, default 6, equal to log2(DEPTH).
REQ-003 SHALL have port clock  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_data  input  32  instruction word from the upstream loader stream.
REQ-006 SHALL have port in_address  input  32  word index paired with in_data; one pair per clock, no valid strobe.
REQ-007 SHALL have port cpu_pc  input  32  CPU byte program counter.
REQ-008 SHALL have port cpu_instr  output  32  registered instruction fetched at cpu_pc.
REQ-009 SHALL have port cpu_reset  output  1  holds the CPU in reset until the image is loaded.
REQ-010 SHALL have port load_done  output  1  image complete and CPU released.
REQ-011 SHALL have port load_count  output  ADDR_W+1  words written in the current pass.
REQ-012 SHALL have port addr_error  output  1  sticky stream-ordering fault flag.
REQ-013 SHALL have port verify_mismatch  output  1  sticky readback-compare fault flag.

Function
REQ-014 SHALL implement states SYNC, LOAD, VERIFY, DONE; SYNC is the reset state.
REQ-015 SYNC: on in_address==0, write in_data to mem[0], set load_count=1, go to LOAD; other addresses are ignored without error.
REQ-016 LOAD: in_address == previous+1 and < DEPTH -> write mem[in_address], increment load_count.
REQ-017 LOAD: in_address out of sequence or >= DEPTH -> no write, set addr_error, clear load_count, return to SYNC.
REQ-018 LOAD: write of in_address==DEPTH-1 -> load_count=DEPTH; next state VERIFY if configured, else DONE.
REQ-019 DONE SHALL be terminal until reset; the stream is ignored and memory is never written in DONE.
REQ-020 cpu_reset SHALL be 1 in all states except DONE; it falls on the first cycle after entry to DONE, together with load_done rising.
REQ-021 cpu_instr SHALL be mem[cpu_pc[ADDR_W+1:2]] registered, one-cycle latency, in DONE only.
REQ-022 cpu_instr SHALL be 32'h00000000 outside DONE, or when cpu_pc[31:ADDR_W+2] is nonzero (out-of-range fetch returns NOP).
REQ-023 cpu_pc[1:0] SHALL be ignored.
REQ-024 A stream wrap (DEPTH-1 followed by 0) in LOAD is the completion case, not an error.
REQ-025 Addresses with bits above ADDR_W set SHALL be treated as >= DEPTH.

Reset
REQ-026 Reset SHALL set state=SYNC, cpu_reset=1, load_done=0, load_count=0, addr_error=0, verify_mismatch=0, cpu_instr=0.
REQ-027 Memory contents SHALL NOT be cleared by reset.
REQ-028 Reset asserted mid-LOAD or mid-VERIFY SHALL abort the pass; the next pass starts from SYNC.
REQ-029 Reset SHALL take priority over every other event in the same cycle.

Configuration
REQ-030 Macro IMEM_BOOT_VERIFY_EN SHALL compile in the VERIFY state.
REQ-031 With the macro, VERIFY waits for in_address==0, then compares in_data against mem[in_address] for DEPTH consecutive words, then enters DONE.
REQ-032 Any compare difference SHALL set verify_mismatch; DONE is still entered.
REQ-033 An ordering fault in VERIFY SHALL set addr_error and restart the compare at the next address 0.
REQ-034 load_count SHALL hold DEPTH throughout VERIFY.
REQ-035 Without the macro, LOAD goes directly to DONE and verify_mismatch is tied to 0.

Verification
REQ-036 Reset, then stream addresses 0..63 with data 0x20000000+addr -> load_done=1 and cpu_reset=0 one cycle after the addr-63 write; load_count=64.
REQ-037 After DONE, cpu_pc=0x00000008 -> cpu_instr=0x20000002 next cycle; cpu_pc=0x00000100 -> cpu_instr=0.
REQ-038 Stream 0,1,2,5 -> addr_error=1, load_count=0, state SYNC; a following clean 0..63 pass -> DONE with addr_error still 1.
REQ-039 Stream starting at addr 17 -> no writes until 0 is seen, then a normal load to DONE.
REQ-040 Reset asserted at addr 30 of a pass -> all outputs at reset values next cycle; a reload completes normally.
REQ-041 With IMEM_BOOT_VERIFY_EN, second pass with word 9 altered -> verify_mismatch=1 and DONE reached after 128 words; without the macro, DONE is reached after 64 words.
